// File: rtl/spi_aes_pkg.sv
// Shared types for the SPI AES frame slave: FSM states, key-size codes, key length lookup.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_MSG,
    RX_KEY,
    START,
    WAIT,
    TX,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] SZ_128 = 2'b00;
  localparam logic [1:0] SZ_192 = 2'b01;
  localparam logic [1:0] SZ_256 = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  // Number of key bits framed on the wire for a given size code; 0 for the illegal code.
  function automatic int unsigned KEY_BITS(input logic [1:0] sz);
    case (sz)
      SZ_128:  return 128;
      SZ_192:  return 192;
      SZ_256:  return 256;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/spi_idx_capture.sv
// Indexed bit-capture register: writes one bit at a time at a given index, with whole-register clear.
// Latency: bit visible on o_q one cycle after i_we.
// Backpressure: none; out-of-range indices are dropped.
module spi_idx_capture #(
  parameter int W     = 128,
  parameter int IDX_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_bit,
  output logic [W-1:0]     o_q
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_q;
  logic          w_in_range;
  logic [BW-1:0] w_bidx;

  assign w_in_range = (32'(i_idx) < W);
  assign w_bidx     = i_idx[BW-1:0];
  assign o_q        = r_q;

  // Clear and write in the same cycle leaves only the written bit set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      if (i_clr) r_q <= '0;
      if (i_we && w_in_range) r_q[w_bidx] <= i_bit;
    end
  end

endmodule

// File: rtl/spi_aes_frame_slave.sv
// SPI slave framing one AES operation: message then key in on simo, result out on somi, LSB first.
// Latency: aes_start 1 cycle after last key bit; first somi bit 2 cycles after aes_done.
// Backpressure: none; css high mid-frame aborts with frame_err, the core is waited on indefinitely.
module spi_aes_frame_slave
  import spi_aes_pkg::*;
#(
  parameter int BLOCK_W   = 128,
  parameter int MAX_KEY_W = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 css,
  input  logic                 simo,
  input  logic                 mode,
  input  logic [1:0]           size,
  output logic                 somi,
  output logic [BLOCK_W-1:0]   aes_msg,
  output logic [MAX_KEY_W-1:0] aes_key,
  output logic                 aes_mode,
  output logic [1:0]           aes_size,
  output logic                 aes_start,
  input  logic                 aes_done,
  input  logic [BLOCK_W-1:0]   aes_result,
  output logic                 busy,
  output logic                 frame_err
);

  // Counter is shared by msg, key and tx phases, so it is sized for the widest key.
  localparam int                CNT_W    = $clog2(MAX_KEY_W) + 1;
  localparam int                RES_IW   = $clog2(BLOCK_W);
  localparam logic [CNT_W-1:0]  MSG_LAST = CNT_W'(BLOCK_W - 1);
  localparam logic [CNT_W-1:0]  TX_END   = CNT_W'(BLOCK_W);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode;
  logic [1:0]         r_size;
  logic [BLOCK_W-1:0] r_result;
  logic               r_somi;
  logic               r_frame_err;
  logic               r_armed;

  logic               w_go;
  logic               w_abort;
  logic               w_msg_clr;
  logic               w_msg_we;
  logic               w_key_clr;
  logic               w_key_we;
  logic [CNT_W-1:0]   w_idx;
  logic [CNT_W-1:0]   w_key_last;
  logic [RES_IW-1:0]  w_tx_idx;

  // A frame may only start after css has been seen high since reset, so a reset
  // taken with css low does not resume into a half-clocked frame.
  assign w_go       = (r_state == IDLE) && !css && r_armed;
  assign w_abort    = css && (r_state inside {RX_MSG, RX_KEY, START, WAIT, TX});
  assign w_idx      = (r_state == IDLE) ? '0 : r_cnt;
  assign w_key_last = CNT_W'(KEY_BITS(r_size) - 1);
  assign w_tx_idx   = r_cnt[RES_IW-1:0];

  assign somi      = r_somi;
  assign aes_mode  = r_mode;
  assign aes_size  = r_size;
  assign aes_start = (r_state == START);
  assign frame_err = r_frame_err;
  assign busy      = (r_state inside {RX_MSG, RX_KEY, START, WAIT, TX}) ||
                     (w_go && (size != SZ_BAD));

  spi_idx_capture #(.W(BLOCK_W), .IDX_W(CNT_W)) u_msg (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_msg_clr),
    .i_we    (w_msg_we),
    .i_idx   (w_idx),
    .i_bit   (simo),
    .o_q     (aes_msg)
  );

  spi_idx_capture #(.W(MAX_KEY_W), .IDX_W(CNT_W)) u_key (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_key_clr),
    .i_we    (w_key_we),
    .i_idx   (w_idx),
    .i_bit   (simo),
    .o_q     (aes_key)
  );

  // Next-state and capture-strobe decode; css high in an active state always wins.
  always_comb begin
    w_next    = r_state;
    w_msg_clr = 1'b0;
    w_msg_we  = 1'b0;
    w_key_clr = 1'b0;
    w_key_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_msg_clr = 1'b1;
          w_key_clr = 1'b1;
          if (size == SZ_BAD) begin
            w_next = ERR;
          end else begin
            w_next   = RX_MSG;
            w_msg_we = 1'b1;
          end
        end
      end
      RX_MSG: begin
        if (css) begin
          w_next = IDLE;
        end else begin
          w_msg_we = 1'b1;
          if (r_cnt == MSG_LAST) w_next = RX_KEY;
        end
      end
      RX_KEY: begin
        if (css) begin
          w_next = IDLE;
        end else begin
          w_key_we = 1'b1;
          if (r_cnt == w_key_last) w_next = START;
        end
      end
      START:   w_next = css ? IDLE : WAIT;
      WAIT:    if (css) w_next = IDLE; else if (aes_done) w_next = TX;
      TX:      if (css) w_next = IDLE; else if (r_cnt == TX_END) w_next = DONE;
      DONE:    if (css) w_next = IDLE;
      ERR:     if (css) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register, shared bit counter, latched mode/size, result capture and somi shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_size      <= SZ_128;
      r_result    <= '0;
      r_somi      <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (css) r_armed <= 1'b1;
      case (r_state)
        IDLE: begin
          r_somi <= 1'b0;
          if (w_go) begin
            r_mode      <= mode;
            r_size      <= size;
            r_frame_err <= (size == SZ_BAD);
            r_cnt       <= (size == SZ_BAD) ? '0 : CNT_W'(1);
          end
        end
        RX_MSG: if (!css) r_cnt <= (r_cnt == MSG_LAST) ? '0 : r_cnt + 1'b1;
        RX_KEY: if (!css && (r_cnt != w_key_last)) r_cnt <= r_cnt + 1'b1;
        WAIT: begin
          if (!css && aes_done) begin
            r_result <= aes_result;
            r_cnt    <= '0;
          end
        end
        // One extra TX cycle keeps the last bit on the line for a full clock before DONE.
        TX: begin
          if (!css && (r_cnt != TX_END)) begin
            r_somi <= r_result[w_tx_idx];
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            r_somi <= 1'b0;
          end
        end
        default: r_somi <= 1'b0;
      endcase
      if (w_abort) begin
        r_frame_err <= 1'b1;
        r_somi      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_aes_frame_slave.sv
// Scoreboard bench for spi_aes_frame_slave with a stub AES core.
// Latency: driver predicts aes_start cycle and somi stream from frame rules.
// Backpressure: stub core answers after a per-frame programmable latency.
module tb_spi_aes_frame_slave;

  typedef struct {
    logic [127:0] msg;
    logic [255:0] key;
    logic         mode;
    logic [1:0]   size;
    int           start_cyc;
    int           lat;
    logic [127:0] res;
    int           rst_bit;
  } exp_t;

  typedef struct {
    int           lat;
    logic [127:0] res;
  } stub_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         css;
  logic         simo;
  logic         mode;
  logic [1:0]   size;
  logic         somi;
  logic [127:0] aes_msg;
  logic [255:0] aes_key;
  logic         aes_mode;
  logic [1:0]   aes_size;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_result;
  logic         busy;
  logic         frame_err;

  logic         stub_done = 1'b0;
  logic [127:0] stub_res  = '0;
  logic         spur_done;
  logic [127:0] spur_res;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  exp_t  exp_q[$];
  stub_t stub_q[$];

  assign aes_done   = stub_done | spur_done;
  assign aes_result = spur_done ? spur_res : stub_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_aes_frame_slave #(.BLOCK_W(128), .MAX_KEY_W(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .css        (css),
    .simo       (simo),
    .mode       (mode),
    .size       (size),
    .somi       (somi),
    .aes_msg    (aes_msg),
    .aes_key    (aes_key),
    .aes_mode   (aes_mode),
    .aes_size   (aes_size),
    .aes_start  (aes_start),
    .aes_done   (aes_done),
    .aes_result (aes_result),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int kbits(input logic [1:0] s);
    return 128 + 64 * int'(s);
  endfunction

  function automatic logic [255:0] mask_key(input logic [255:0] k, input logic [1:0] s);
    logic [255:0] m;
    m = k;
    for (int i = kbits(s); i < 256; i++) m[i] = 1'b0;
    return m;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] r256();
    return {r128(), r128()};
  endfunction

  // Stub core: answers each aes_start with the queued result after the queued latency.
  initial begin : stub
    stub_t s;
    forever begin
      @(negedge clk);
      if (aes_start && stub_q.size() > 0) begin
        s = stub_q.pop_front();
        repeat (s.lat) @(negedge clk);
        stub_res  = s.res;
        stub_done = 1'b1;
        @(negedge clk);
        stub_done = 1'b0;
      end
    end
  end

  // Monitor: every aes_start is matched against the next expected frame, then its somi stream.
  initial begin : monitor
    exp_t        e;
    logic [127:0] got;
    logic [127:0] msk;
    int           nb;
    forever begin
      @(negedge clk);
      if (aes_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 256'(aes_start), 256'(0));
        end else begin
          e = exp_q.pop_front();
          chk("start_cycle", 256'(cyc), 256'(e.start_cyc));
          chk("start_msg", 256'(aes_msg), 256'(e.msg));
          chk("start_key", aes_key, e.key);
          chk("start_mode", 256'(aes_mode), 256'(e.mode));
          chk("start_size", 256'(aes_size), 256'(e.size));
          repeat (e.lat) @(negedge clk);
          chk("wait_stable", {aes_msg, aes_key[127:0]} ^ {e.msg, e.key[127:0]}, 256'(0));
          repeat (2) @(negedge clk);
          nb  = (e.rst_bit >= 0) ? e.rst_bit : 128;
          got = '0;
          msk = '0;
          for (int k = 0; k < nb; k++) begin
            got[k] = somi;
            msk[k] = 1'b1;
            @(negedge clk);
          end
          chk("somi_stream", 256'(got), 256'(e.res & msk));
          if (e.rst_bit < 0) begin
            chk("done_somi", 256'(somi), 256'(0));
            chk("done_busy", 256'(busy), 256'(0));
          end
        end
      end
    end
  end

  task automatic send_frame(input logic md, input logic [1:0] sz, input logic [127:0] msg,
                            input logic [255:0] key, input logic [127:0] res, input int lat,
                            input int abort_at, input int extra, input int spur_at,
                            input int rst_bit);
    int    kb;
    int    nbits;
    int    s_cyc;
    bit    legal;
    logic  somi_nz;
    exp_t  e;
    stub_t st;
    legal   = (sz != 2'b11);
    kb      = legal ? kbits(sz) : 0;
    nbits   = legal ? 128 + kb : 300;
    somi_nz = 1'b0;
    @(negedge clk);
    s_cyc = cyc + 128 + kb;
    css   = 1'b0;
    mode  = md;
    size  = sz;
    simo  = msg[0];
    if (legal && abort_at < 0) begin
      e.msg = msg; e.key = mask_key(key, sz); e.mode = md; e.size = sz;
      e.start_cyc = s_cyc; e.lat = lat; e.res = res; e.rst_bit = rst_bit;
      exp_q.push_back(e);
      st.lat = lat; st.res = res;
      stub_q.push_back(st);
    end
    for (int b = 1; b < nbits; b++) begin
      @(negedge clk);
      spur_done = 1'b0;
      if (b == 1) begin
        mode = ~md;
        size = 2'($urandom);
      end
      if (b == 3) begin
        chk("frame_err_at_start", 256'(frame_err), 256'(!legal));
        chk("busy_at_start", 256'(busy), 256'(legal));
      end
      if (b == abort_at) begin
        css = 1'b1;
        @(negedge clk);
        chk("abort_frame_err", 256'(frame_err), 256'(1));
        chk("abort_busy", 256'(busy), 256'(0));
        repeat (2) @(negedge clk);
        return;
      end
      if (!legal) begin
        simo    = 1'($urandom);
        somi_nz = somi_nz | somi;
      end else begin
        simo = (b < 128) ? msg[b] : key[b - 128];
        if (b == 128 + spur_at) begin
          spur_res  = r128();
          spur_done = 1'b1;
        end
      end
    end
    if (!legal) begin
      @(negedge clk);
      chk("err_frame_err", 256'(frame_err), 256'(1));
      chk("err_busy", 256'(busy), 256'(0));
      chk("err_somi_quiet", 256'(somi_nz | somi), 256'(0));
      css = 1'b1;
      repeat (3) @(negedge clk);
      return;
    end
    if (rst_bit >= 0) begin
      for (int m = 0; m < lat + 3 + rst_bit; m++) begin
        @(negedge clk);
        spur_done = 1'b0;
        simo = 1'($urandom);
      end
      reset = 1'b0;
      #1;
      chk("rst_somi", 256'(somi), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      @(negedge clk);
      reset = 1'b1;
      for (int m = 0; m < 20; m++) begin
        @(negedge clk);
        simo = 1'($urandom);
      end
      chk("rst_no_restart_busy", 256'(busy), 256'(0));
      chk("rst_no_restart_msg", 256'(aes_msg), 256'(0));
      css = 1'b1;
      repeat (3) @(negedge clk);
      return;
    end
    for (int m = 0; m < lat + 132 + extra; m++) begin
      @(negedge clk);
      spur_done = 1'b0;
      simo = 1'($urandom);
    end
    chk("tail_somi", 256'(somi), 256'(0));
    chk("tail_busy", 256'(busy), 256'(0));
    chk("tail_frame_err", 256'(frame_err), 256'(0));
    chk("tail_msg", 256'(aes_msg), 256'(msg));
    chk("tail_key", aes_key, mask_key(key, sz));
    chk("tail_mode_size", 256'({aes_mode, aes_size}), 256'({md, sz}));
    css = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : main
    logic [1:0] sz;
    reset     = 1'b0;
    css       = 1'b1;
    simo      = 1'b0;
    mode      = 1'b0;
    size      = 2'b00;
    spur_done = 1'b0;
    spur_res  = '0;
    repeat (3) @(negedge clk);
    chk("reset_somi", 256'(somi), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_frame_err", 256'(frame_err), 256'(0));
    chk("reset_start", 256'(aes_start), 256'(0));
    chk("reset_msg", 256'(aes_msg), 256'(0));
    chk("reset_key", aes_key, 256'(0));
    reset = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(1'b0, 2'b00, 128'h00112233445566778899aabbccddeeff,
               256'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, -1, 0, -1, -1);
    send_frame(1'b1, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
               256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 10, -1, 0, -1, -1);
    send_frame(1'b0, 2'b11, r128(), r256(), r128(), 5, -1, 0, -1, -1);
    send_frame(1'b1, 2'b01, r128(), r256(), r128(), 5, 200, 0, -1, -1);
    send_frame(1'b0, 2'b01, r128(), r256(), r128(), 7, -1, 0, -1, -1);
    send_frame(1'b0, 2'b00, r128(), r256(), r128(), 12, -1, 20, 10, -1);
    send_frame(1'b1, 2'b00, r128(), r256(), r128(), 8, -1, 0, -1, 50);
    for (int i = 0; i < 5; i++) begin
      sz = 2'($urandom_range(0, 2));
      send_frame(1'($urandom), sz, r128(), r256(), r128(), int'($urandom_range(1, 20)),
                 -1, int'($urandom_range(0, 5)), -1, -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
